// File: rtl/maple_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : maple_rx_ctrl_if
// Brief    : Host, maple_in and byte-buffer signals of the Maple RX controller
// Revision : 1.0 - initial release
// ============================================================================
interface maple_rx_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              start_rx;
  logic              abort;
  logic              mi_start_detected;
  logic              mi_end_detected;
  logic [7:0]        mi_fifo_data;
  logic              mi_data_produce;
  logic              mi_trigger_start;
  logic              mi_trigger_end;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              busy;
  logic              done;
  logic [2:0]        status;
  logic [ADDR_W:0]   rx_count;

  // Controller side
  modport slave (
    input  start_rx, abort, mi_start_detected, mi_end_detected,
           mi_fifo_data, mi_data_produce,
    output mi_trigger_start, mi_trigger_end, buf_we, buf_addr, buf_data,
           busy, done, status, rx_count
  );

  // Host / deserialiser / buffer side
  modport master (
    output start_rx, abort, mi_start_detected, mi_end_detected,
           mi_fifo_data, mi_data_produce,
    input  mi_trigger_start, mi_trigger_end, buf_we, buf_addr, buf_data,
           busy, done, status, rx_count
  );
endinterface
`default_nettype wire

// File: rtl/maple_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : maple_rx_ctrl
// Brief    : Sequences one Maple bus receive transaction around maple_in,
//            buffers the bytes and reports a per-transaction status code.
// Revision : 1.0 - initial release
// ============================================================================
module maple_rx_ctrl #(
  parameter int ADDR_W   = 11,
  parameter int START_TO = 100000,
  parameter int BYTE_TO  = 5000,
  parameter int TO_W     = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  maple_rx_ctrl_if.slave bus
);

  localparam int c_CNT_W = ADDR_W + 1;
  localparam int c_CMP_W = (c_CNT_W > 11) ? c_CNT_W : 11;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_ARM    = 3'd1;
  localparam logic [2:0] c_ST_WAIT   = 3'd2;
  localparam logic [2:0] c_ST_RECV   = 3'd3;
  localparam logic [2:0] c_ST_CHECK  = 3'd4;
  localparam logic [2:0] c_ST_FINISH = 3'd5;

  localparam logic [2:0] c_STS_OK       = 3'd0;
  localparam logic [2:0] c_STS_NO_START = 3'd1;
  localparam logic [2:0] c_STS_TIMEOUT  = 3'd2;
  localparam logic [2:0] c_STS_LENGTH   = 3'd3;
  localparam logic [2:0] c_STS_CHECKSUM = 3'd4;
  localparam logic [2:0] c_STS_OVERFLOW = 3'd5;
  localparam logic [2:0] c_STS_ABORTED  = 3'd6;

  logic [2:0]         r_state;
  logic               r_prev_start;
  logic               r_prev_end;
  logic [TO_W-1:0]    r_timer;
  logic [c_CNT_W-1:0] r_rx_count;
  logic [7:0]         r_xor;
  logic [7:0]         r_len_words;
  logic               r_ovf;
  logic               r_trig_start;
  logic               r_trig_end;
  logic               r_buf_we;
  logic [ADDR_W-1:0]  r_buf_addr;
  logic [7:0]         r_buf_data;
  logic               r_busy;
  logic               r_done;
  logic [2:0]         r_status;

  logic        w_start_ev;
  logic        w_end_ev;
  logic        w_active;
  logic [10:0] w_exp_len;
  logic        w_len_bad;

  assign w_start_ev = bus.mi_start_detected & ~r_prev_start;
  assign w_end_ev   = bus.mi_end_detected & ~r_prev_end;
  assign w_active   = (r_state == c_ST_ARM) || (r_state == c_ST_WAIT) ||
                      (r_state == c_ST_RECV) || (r_state == c_ST_CHECK);
  // Frame length is header(4) + payload words + checksum byte.
  assign w_exp_len  = {1'b0, r_len_words, 2'b00} + 11'd5;
  assign w_len_bad  = c_CMP_W'(r_rx_count) != c_CMP_W'(w_exp_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_IDLE;
      r_prev_start <= 1'b0;
      r_prev_end   <= 1'b0;
      r_timer      <= '0;
      r_rx_count   <= '0;
      r_xor        <= 8'd0;
      r_len_words  <= 8'd0;
      r_ovf        <= 1'b0;
      r_trig_start <= 1'b0;
      r_trig_end   <= 1'b0;
      r_buf_we     <= 1'b0;
      r_buf_addr   <= '0;
      r_buf_data   <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_status     <= c_STS_OK;
    end else begin
      r_trig_start <= 1'b0;
      r_trig_end   <= 1'b0;
      r_buf_we     <= 1'b0;
      r_done       <= 1'b0;

      if (r_state == c_ST_ARM) begin
        r_prev_start <= 1'b0;
        r_prev_end   <= 1'b0;
      end else begin
        r_prev_start <= bus.mi_start_detected;
        r_prev_end   <= bus.mi_end_detected;
      end

      if (bus.abort && w_active) begin
        r_state    <= c_ST_FINISH;
        r_status   <= c_STS_ABORTED;
        r_trig_end <= 1'b1;
        r_done     <= 1'b1;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            if (bus.start_rx) begin
              r_state      <= c_ST_ARM;
              r_trig_start <= 1'b1;
              r_busy       <= 1'b1;
              r_rx_count   <= '0;
              r_xor        <= 8'd0;
              r_len_words  <= 8'd0;
              r_timer      <= '0;
              r_ovf        <= 1'b0;
            end
          end

          c_ST_ARM: r_state <= c_ST_WAIT;

          c_ST_WAIT: begin
            if (w_start_ev) begin
              r_state <= c_ST_RECV;
              r_timer <= '0;
            end else if (r_timer == TO_W'(START_TO - 1)) begin
              r_state    <= c_ST_FINISH;
              r_status   <= c_STS_NO_START;
              r_trig_end <= 1'b1;
              r_done     <= 1'b1;
            end else begin
              r_timer <= r_timer + TO_W'(1);
            end
          end

          c_ST_RECV: begin
            // A byte strobed together with end of frame is still taken.
            if (bus.mi_data_produce) begin
              if (!r_rx_count[ADDR_W]) begin
                r_buf_we   <= 1'b1;
                r_buf_addr <= r_rx_count[ADDR_W-1:0];
                r_buf_data <= bus.mi_fifo_data;
              end else begin
                r_ovf <= 1'b1;
              end
              if (!(&r_rx_count)) r_rx_count <= r_rx_count + c_CNT_W'(1);
              r_xor <= r_xor ^ bus.mi_fifo_data;
              if (r_rx_count == c_CNT_W'(3)) r_len_words <= bus.mi_fifo_data;
            end

            if (w_end_ev) begin
              r_state <= c_ST_CHECK;
            end else if (bus.mi_data_produce) begin
              r_timer <= '0;
            end else if (r_timer == TO_W'(BYTE_TO - 1)) begin
              r_state    <= c_ST_FINISH;
              r_status   <= c_STS_TIMEOUT;
              r_trig_end <= 1'b1;
              r_done     <= 1'b1;
            end else begin
              r_timer <= r_timer + TO_W'(1);
            end
          end

          c_ST_CHECK: begin
            r_state <= c_ST_FINISH;
            r_done  <= 1'b1;
            if (r_ovf)           r_status <= c_STS_OVERFLOW;
            else if (w_len_bad)  r_status <= c_STS_LENGTH;
            else if (r_xor != 0) r_status <= c_STS_CHECKSUM;
            else                 r_status <= c_STS_OK;
          end

          c_ST_FINISH: begin
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
          end

          default: r_state <= c_ST_IDLE;
        endcase
      end
    end
  end

  assign bus.mi_trigger_start = r_trig_start;
  assign bus.mi_trigger_end   = r_trig_end;
  assign bus.buf_we           = r_buf_we;
  assign bus.buf_addr         = r_buf_addr;
  assign bus.buf_data         = r_buf_data;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.status           = r_status;
  assign bus.rx_count         = r_rx_count;

endmodule
`default_nettype wire

// File: tb/tb_maple_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_maple_rx_ctrl
// Brief    : Scoreboard bench for maple_rx_ctrl with directed frames
// Revision : 1.0 - initial release
// ============================================================================
module tb_maple_rx_ctrl;

  localparam int ADDR_W   = 4;
  localparam int START_TO = 40;
  localparam int BYTE_TO  = 30;
  localparam int TO_W     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  int ts_cnt = 0, te_cnt = 0, done_cnt = 0;
  int ts_cyc = 0, we_cyc = 0, done_cyc = 0;

  logic [ADDR_W-1:0] q_waddr[$];
  logic [7:0]        q_wdata[$];
  logic [2:0]        q_st[$];
  logic [ADDR_W:0]   q_cnt[$];
  logic [7:0]        frame[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maple_rx_ctrl_if #(.ADDR_W(ADDR_W)) u_bus ();

  maple_rx_ctrl #(
    .ADDR_W  (ADDR_W),
    .START_TO(START_TO),
    .BYTE_TO (BYTE_TO),
    .TO_W    (TO_W)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT writes or completes
  always @(negedge clk) begin
    logic [ADDR_W-1:0] ea;
    logic [7:0]        ed;
    logic [2:0]        es;
    logic [ADDR_W:0]   ec;
    if (u_bus.mi_trigger_start || u_bus.mi_trigger_end)
      chk("trig_exclusive", 32'(u_bus.mi_trigger_start & u_bus.mi_trigger_end), 32'd0);
    if (u_bus.mi_trigger_start) begin ts_cnt++; ts_cyc = cyc; end
    if (u_bus.mi_trigger_end) te_cnt++;
    if (u_bus.buf_we) begin
      we_cyc = cyc;
      if (q_waddr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0d data %02h, no write expected",
                 u_bus.buf_addr, u_bus.buf_data);
      end else begin
        ea = q_waddr.pop_front();
        ed = q_wdata.pop_front();
        chk("buf_addr", 32'(u_bus.buf_addr), 32'(ea));
        chk("buf_data", 32'(u_bus.buf_data), 32'(ed));
      end
    end
    if (u_bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      if (q_st.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: status %0d rx_count %0d, no done expected",
                 u_bus.status, u_bus.rx_count);
      end else begin
        es = q_st.pop_front();
        ec = q_cnt.pop_front();
        chk("status", 32'(u_bus.status), 32'(es));
        chk("rx_count", 32'(u_bus.rx_count), 32'(ec));
      end
    end
  end

  task automatic begin_rx();
    int n0;
    n0 = ts_cnt;
    u_bus.start_rx = 1'b1;
    tick();
    u_bus.start_rx = 1'b0;
    for (int i = 0; i < 4 && ts_cnt == n0; i++) tick();
    chk("trigger_start", 32'(ts_cnt - n0), 32'd1);
    chk("busy_armed", 32'(u_bus.busy), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_end);
    u_bus.mi_fifo_data    = b;
    u_bus.mi_data_produce = 1'b1;
    if (with_end) u_bus.mi_end_detected = 1'b1;
    tick();
    u_bus.mi_data_produce = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int limit);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == n0; i++) tick();
    chk("done_seen", 32'(done_cnt - n0), 32'd1);
    chk("busy_after_done", 32'(u_bus.busy), 32'd0);
    u_bus.mi_start_detected = 1'b0;
    u_bus.mi_end_detected   = 1'b0;
  endtask

  task automatic expect_writes(input int n);
    for (int i = 0; i < n && i < (1 << ADDR_W); i++) begin
      q_waddr.push_back(ADDR_W'(i));
      q_wdata.push_back(frame[i]);
    end
  endtask

  task automatic run_frame(input bit end_with_last, input logic [2:0] st,
                           input logic [ADDR_W:0] cnt);
    expect_writes(frame.size());
    q_st.push_back(st);
    q_cnt.push_back(cnt);
    begin_rx();
    u_bus.mi_start_detected = 1'b1;
    tick();
    for (int i = 0; i < frame.size(); i++)
      send_byte(frame[i], end_with_last && (i == frame.size() - 1));
    if (!end_with_last) u_bus.mi_end_detected = 1'b1;
    wait_done(20);
  endtask

  initial begin
    int te0, ts0, dn0;
    u_bus.start_rx          = 1'b0;
    u_bus.abort             = 1'b0;
    u_bus.mi_start_detected = 1'b0;
    u_bus.mi_end_detected   = 1'b0;
    u_bus.mi_fifo_data      = 8'd0;
    u_bus.mi_data_produce   = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(u_bus.busy), 32'd0);
    chk("rst_done", 32'(u_bus.done), 32'd0);
    chk("rst_status", 32'(u_bus.status), 32'd0);
    chk("rst_rx_count", 32'(u_bus.rx_count), 32'd0);
    chk("rst_triggers", 32'({u_bus.mi_trigger_start, u_bus.mi_trigger_end}), 32'd0);
    chk("rst_buf", 32'({u_bus.buf_we, u_bus.buf_addr, u_bus.buf_data}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Good frame: XOR of first 8 bytes is 0x20
    frame = '{8'h01, 8'h00, 8'h20, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h20};
    run_frame(1'b0, 3'd0, 5'd9);
    // Checksum byte flipped
    frame = '{8'h01, 8'h00, 8'h20, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h21};
    run_frame(1'b0, 3'd4, 5'd9);
    // Length says 13 bytes, 9 sent; last byte coincides with end of frame
    frame = '{8'h01, 8'h00, 8'h20, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h23};
    run_frame(1'b1, 3'd3, 5'd9);
    // Minimal frame: zero payload words, 5 bytes
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(1'b0, 3'd0, 5'd5);

    // No start pattern
    q_st.push_back(3'd1);
    q_cnt.push_back(5'd0);
    te0 = te_cnt;
    begin_rx();
    wait_done(START_TO + 10);
    chk("nostart_trig_end", 32'(te_cnt - te0), 32'd1);
    chk("nostart_latency", 32'(done_cyc - ts_cyc), 32'(START_TO + 1));

    // Inter-byte timeout after two bytes
    frame = '{8'h11, 8'h22};
    expect_writes(2);
    q_st.push_back(3'd2);
    q_cnt.push_back(5'd2);
    te0 = te_cnt;
    begin_rx();
    u_bus.mi_start_detected = 1'b1;
    tick();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    wait_done(BYTE_TO + 10);
    chk("timeout_trig_end", 32'(te_cnt - te0), 32'd1);
    chk("timeout_latency", 32'(done_cyc - we_cyc), 32'(BYTE_TO));

    // Buffer overflow (16 entries) and rx_count saturation at 31
    frame.delete();
    for (int i = 0; i < 20; i++) frame.push_back(8'(i));
    run_frame(1'b0, 3'd5, 5'd20);
    frame.delete();
    for (int i = 0; i < 35; i++) frame.push_back(8'(i + 3));
    run_frame(1'b0, 3'd5, 5'd31);

    // Abort coincident with a byte strobe; start_rx while busy is ignored
    frame = '{8'h5A, 8'hA5};
    expect_writes(2);
    q_st.push_back(3'd6);
    q_cnt.push_back(5'd2);
    begin_rx();
    u_bus.mi_start_detected = 1'b1;
    tick();
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    ts0 = ts_cnt;
    u_bus.start_rx = 1'b1;
    tick();
    u_bus.start_rx = 1'b0;
    repeat (2) tick();
    chk("busy_start_ignored", 32'(ts_cnt - ts0), 32'd0);
    te0 = te_cnt;
    u_bus.abort           = 1'b1;
    u_bus.mi_fifo_data    = 8'h77;
    u_bus.mi_data_produce = 1'b1;
    tick();
    u_bus.abort           = 1'b0;
    u_bus.mi_data_produce = 1'b0;
    wait_done(10);
    chk("abort_trig_end", 32'(te_cnt - te0), 32'd1);

    // Asynchronous reset in the middle of RECEIVE
    frame = '{8'h3C, 8'hC3};
    expect_writes(2);
    begin_rx();
    u_bus.mi_start_detected = 1'b1;
    tick();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    dn0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(u_bus.busy), 32'd0);
    chk("arst_status", 32'(u_bus.status), 32'd0);
    chk("arst_rx_count", 32'(u_bus.rx_count), 32'd0);
    chk("arst_buf_we", 32'(u_bus.buf_we), 32'd0);
    u_bus.mi_start_detected = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("arst_no_done", 32'(done_cnt - dn0), 32'd0);

    // Recovery after reset
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(1'b0, 3'd0, 5'd5);

    chk("writes_drained", 32'(q_waddr.size()), 32'd0);
    chk("dones_drained", 32'(q_st.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/maple_rx_ctrl.md
Name: maple_rx_ctrl

Overview:
Sequences one Maple bus receive transaction around the maple_in deserialiser. It arms the deserialiser after the host side finishes transmitting and watches for start and end of frame. Received bytes are stored in a byte buffer, and the frame is checked for length, checksum, overflow and timeouts. It reports one status code per transaction to the host/OSD controller.

Parameters:
ADDR_W, 11, byte buffer address width (max 2^ADDR_W stored bytes)
START_TO, 100000, clk cycles allowed from arm to start pattern
BYTE_TO, 5000, max clk cycles between received bytes once started
TO_W, 17, timeout counter width (must hold max(START_TO, BYTE_TO))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_rx  in  1  one-cycle pulse: host transmit finished, begin receive
abort  in  1  one-cycle pulse: cancel current transaction
mi_start_detected  in  1  level from maple_in, held until next trigger
mi_end_detected  in  1  level from maple_in, held until next trigger
mi_fifo_data  in  8  received byte
mi_data_produce  in  1  one-cycle strobe, mi_fifo_data valid
mi_trigger_start  out  1  one-cycle pulse arming maple_in
mi_trigger_end  out  1  one-cycle pulse disarming maple_in
buf_we  out  1  buffer write strobe
buf_addr  out  ADDR_W  buffer write address
buf_data  out  8  buffer write data
busy  out  1  transaction in progress
done  out  1  one-cycle pulse, status/rx_count valid
status  out  3  0 OK, 1 NO_START, 2 TIMEOUT, 3 LENGTH, 4 CHECKSUM, 5 OVERFLOW, 6 ABORTED
rx_count  out  ADDR_W+1  bytes received (saturating at all-ones)

Behaviour:
- Reset: all outputs 0; state IDLE; counters, checksum and length register 0.
- All outputs are registered.
- Edge detect: start_ev/end_ev are the rising edges of mi_start_detected/mi_end_detected, using a registered previous value. Edge history clears in ARM.
- IDLE:
  - start_rx -> ARM.
  - abort ignored.
  - status/rx_count hold the previous result.
- ARM (1 cycle):
  - mi_trigger_start=1; busy=1.
  - Clear rx_count, xor_acc, len_words, timer, ovf.
  - Next state WAIT_START.
- WAIT_START:
  - timer increments each cycle.
  - start_ev -> RECEIVE, timer=0.
  - timer==START_TO-1 without start_ev -> FINISH with NO_START, mi_trigger_end=1.
- RECEIVE, on mi_data_produce:
  - If rx_count < 2^ADDR_W: buf_we=1, buf_addr=rx_count[ADDR_W-1:0], buf_data=mi_fifo_data (same cycle as the registered outputs update).
  - Otherwise: no write, ovf=1.
  - rx_count increments, saturating.
  - xor_acc ^= byte.
  - If rx_count==3 (4th byte): len_words=byte.
  - timer=0.
- RECEIVE, timing and end:
  - With no byte, timer increments.
  - timer==BYTE_TO-1 -> FINISH with TIMEOUT, mi_trigger_end=1.
  - end_ev -> CHECK. A byte strobed in the same cycle as end_ev is processed first.
- CHECK (1 cycle), status selected in priority order:
  - ovf -> OVERFLOW
  - rx_count != 4*len_words+5 (11-bit arithmetic) -> LENGTH
  - xor_acc != 0 -> CHECKSUM
  - else OK
  - Next state FINISH.
  - No trigger_end, since maple_in has already dropped active.
- FINISH (1 cycle): done=1; busy=0 on the following cycle; return to IDLE.
- Abort in ARM/WAIT_START/RECEIVE/CHECK: status=ABORTED, mi_trigger_end=1, -> FINISH. Abort wins over any same-cycle event.
- start_rx while busy: ignored.
- mi_data_produce outside RECEIVE: ignored (no write, no count).
- mi_trigger_start and mi_trigger_end are never high together.
- Async reset mid-transaction: immediate return to reset values; no done pulse.

Test Plan:
1. Good frame, start_rx then start_ev, bytes 01 00 20 01 AA BB CC DD x, x = XOR of the first 8 bytes, then end_ev -> 9 writes at addr 0..8, then done with status=0, rx_count=9.
2. Same frame with x flipped -> status=4 (CHECKSUM), rx_count=9, all 9 bytes still written.
3. Frame with length byte 02 but only 9 bytes -> status=3 (LENGTH). Byte strobe coincident with end_ev -> byte counted and written.
4. start_rx, no start_ev for START_TO cycles -> mi_trigger_end pulse, then done with status=1. Start, 2 bytes, then silence BYTE_TO cycles -> status=2.
5. ADDR_W=3, 10-byte frame -> writes only at addr 0..7, status=5 (OVERFLOW), rx_count=10.
6. abort coincident with mi_data_produce in RECEIVE -> no write, mi_trigger_end=1, status=6. start_rx while busy -> no second mi_trigger_start. rst_n low mid-RECEIVE -> outputs 0, no done.
